// File: rtl/upcnt_pkg.sv
// Shared defaults and the occupancy-width helper for the counter FIFO stage.
package upcnt_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 512;

    // Occupancy spans 0..depth inclusive, so one bit wider than a pointer.
    function automatic int unsigned LVL_W(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/upcounter_fifo_ctrl_sync_fifo_fwft.sv
// First-word fall-through synchronous FIFO: RAM for the body, a head register for the oldest word.
module sync_fifo_fwft
    import upcnt_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic                      ready_i,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      valid_o,
    output logic [LVL_W(DEPTH)-1:0]   level_o,
    output logic [LVL_W(DEPTH)-1:0]   level_next_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = LVL_W(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d, ram_cnt;
    logic [DATA_W-1:0] head_q, head_d;
    logic              head_vld_q, head_vld_d;
    logic              pop, refill, from_ram, bypass, ram_wr;

    always_comb begin
        pop      = head_vld_q && ready_i;
        refill   = pop || !head_vld_q;
        ram_cnt  = level_q - LvlW'(head_vld_q);
        from_ram = refill && (ram_cnt != '0);
        // Nothing queued behind the head: a new word goes straight to the output.
        bypass   = refill && (ram_cnt == '0) && push_i;
        ram_wr   = push_i && !bypass;

        head_d     = head_q;
        head_vld_d = head_vld_q && !pop;
        if (from_ram) begin
            head_d     = mem_q[rd_ptr_q];
            head_vld_d = 1'b1;
        end else if (bypass) begin
            head_d     = wdata_i;
            head_vld_d = 1'b1;
        end

        rd_ptr_d = rd_ptr_q + PtrW'(from_ram);
        wr_ptr_d = wr_ptr_q + PtrW'(ram_wr);

        level_d = level_q;
        if (push_i && !pop) begin
            level_d = level_q + LvlW'(1);
        end else if (pop && !push_i) begin
            level_d = level_q - LvlW'(1);
        end
    end

    // Head register doubles as the RAM read-data register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_wr && !rst_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o      = head_q;
    assign valid_o      = head_vld_q;
    assign level_o      = level_q;
    assign level_next_o = rst_i ? '0 : level_d;

endmodule

// File: rtl/upcounter_fifo_ctrl.sv
// Counter-word buffer: drives counter_en, queues words, flags almost-full.
// Optional continuity checker enabled by defining UPCNT_SEQ_CHECK_EN.
module upcounter_fifo_ctrl
    import upcnt_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned DEPTH        = DEPTH_DEF,
    parameter int unsigned AFULL_THRESH = DEPTH - 16
) (
    input  logic                    clk,
    input  logic                    reset_,
    input  logic                    run,
    input  logic [DATA_W-1:0]       data_gen_stream_in,
    output logic                    counter_en,
    output logic                    upcounterfifo_AlmostFull,
    output logic [DATA_W-1:0]       dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic [LVL_W(DEPTH)-1:0] level,
    output logic                    seq_err
);

    localparam int unsigned LvlW = LVL_W(DEPTH);

    logic [LvlW-1:0] level_next;
    logic            afull_q;
    logic            pop;

    // Full check uses only the registered level, so a same-cycle pop never frees a slot early.
    assign counter_en = run && !reset_ && (level != LvlW'(DEPTH));
    assign pop        = dout_valid && dout_ready;

    sync_fifo_fwft #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .rst_i        (reset_),
        .push_i       (counter_en),
        .wdata_i      (data_gen_stream_in),
        .ready_i      (dout_ready),
        .rdata_o      (dout),
        .valid_o      (dout_valid),
        .level_o      (level),
        .level_next_o (level_next)
    );

    always_ff @(posedge clk) begin
        if (reset_) begin
            afull_q <= 1'b0;
        end else begin
            afull_q <= (level_next >= LvlW'(AFULL_THRESH));
        end
    end

    assign upcounterfifo_AlmostFull = afull_q;

`ifdef UPCNT_SEQ_CHECK_EN
    logic [DATA_W-1:0] prev_q;
    logic              prev_vld_q;
    logic              seq_err_q;

    always_ff @(posedge clk) begin
        if (reset_) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else if (pop) begin
            prev_q     <= dout;
            prev_vld_q <= 1'b1;
            if (prev_vld_q && (dout != prev_q + DATA_W'(1))) begin
                seq_err_q <= 1'b1;
            end
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: doc/upcounter_fifo_ctrl.md
# upcounter_fifo_ctrl

Buffer stage directly downstream of the stream-IN counter data generator. It drives the generator's `counter_en`, captures every counter word into an on-chip FIFO, and feeds the words to the slave-FIFO write logic through a valid/ready handshake. It also produces `upcounterfifo_AlmostFull` for status and throttling. No word is ever dropped or duplicated.

## Interface

Parameters:
- `DATA_W`, 32: word width; must match the generator output.
- `DEPTH`, 512: FIFO depth in words; must be a power of 2, ≥ 4.
- `AFULL_THRESH`, `DEPTH-16`: `upcounterfifo_AlmostFull` asserts when level ≥ this value; legal range 1..DEPTH.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `reset_`, in, 1: synchronous, active-high reset.
- `run`, in, 1: enables word generation.
- `data_gen_stream_in`, in, DATA_W: current counter value from the generator.
- `counter_en`, out, 1: tells the generator to advance; a word is written in the same cycle.
- `upcounterfifo_AlmostFull`, out, 1: level ≥ `AFULL_THRESH`.
- `dout`, out, DATA_W: head-of-FIFO word (first-word fall-through).
- `dout_valid`, out, 1: FIFO is not empty.
- `dout_ready`, in, 1: consumer accepts `dout` this cycle.
- `level`, out, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `seq_err`, out, 1: sticky continuity error (see Configuration).

## Operation
- Write rule: `counter_en = run && (level != DEPTH)`.
  - Combinational from the registered level; no other path.
  - When `counter_en` is 1, the value on `data_gen_stream_in` in that cycle is written.
  - The generator increments on the same edge, so each counter value is written exactly once.
- Read rule: a pop occurs when `dout_valid && dout_ready`.
  - `dout` holds the oldest word while `dout_valid` is 1.
  - `dout` is don't-care while `dout_valid` is 0.
- Simultaneous push and pop: `level` is unchanged and both take effect.
- Full (`level == DEPTH`): `counter_en` is 0 even if a pop happens in that cycle. The write resumes one cycle later.
- Empty: `dout_valid` is 0. `dout_ready` is ignored and `level` never underflows.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. `level` is a separate saturating-free up/down counter.
- `upcounterfifo_AlmostFull` is registered; it reflects the post-edge level.
- Deasserting `run` stops writes immediately. The read side keeps draining.
- Reset, including mid-transfer:
  - Pointers and `level` go to 0; buffered data is discarded.
  - Outputs: `dout_valid`=0, `upcounterfifo_AlmostFull`=0, `seq_err`=0, `dout`=0.
  - `counter_en` is 0 during the reset cycle, forced regardless of `run`.

## Timing
- Write-to-read latency:
  - A word written at edge N appears on `dout` with `dout_valid`=1 after edge N (cycle N+1).
  - This holds whether the FIFO was empty or not.
- Sustained throughput is one word per clock when `dout_ready` is held at 1. `level` then stays at ≤1.
- Level and flags:
  - `level` and `upcounterfifo_AlmostFull` update on the edge at which the push or pop occurs.
  - `upcounterfifo_AlmostFull` deasserts on the edge where the level drops below the threshold.
- Storage is a registered-read RAM plus a one-word output register to provide fall-through. The prefetch adds no visible latency beyond the rule above.

## Configuration
- Macro: `UPCNT_SEQ_CHECK_EN`.
- Defined:
  - Each popped word is compared with the previously popped word + 1, modulo 2^DATA_W.
  - A mismatch sets `seq_err`, which stays set until reset.
  - The first pop after reset is not checked.
  - The check uses the popped word only, so it costs no added latency.
- Not defined: `seq_err` is tied to 0 and no checker registers exist.

## Structure
- Package `upcnt_pkg`:
  - `DATA_W_DEF` = 32 and `DEPTH_DEF` = 512.
  - `level_t` width function `LVL_W(depth)` = $clog2(depth)+1.
- Sub-module `sync_fifo_fwft`: storage, pointers, level and fall-through register.
- Top `upcounter_fifo_ctrl`: `counter_en` logic, almost-full register and the optional sequence checker.

## Test plan
- Flow-through: reset, `run`=1, `dout_ready`=1, counter model starting at 0 → `dout` sequence 0,1,2,… one per cycle from the cycle after first `counter_en`; `level` ≤ 1; `seq_err`=0.
- Fill:
  - Stimulus: `dout_ready`=0, `run`=1, DEPTH=512.
  - `counter_en` is high for exactly 512 cycles, then 0.
  - `upcounterfifo_AlmostFull` rises when `level` reaches 496.
  - `level`=512.
- Drain and resume:
  - Start from full; set `dout_ready`=1 for one cycle.
  - `dout`=0 is popped and `level` drops to 511.
  - `counter_en` returns to 1 on the next cycle and writes 512.
- Random backpressure: `dout_ready` toggled randomly for 10,000 cycles → received stream strictly consecutive, no gaps or duplicates, `level` never exceeds 512.
- Reset mid-operation: assert `reset_` at `level`=200 → next cycle `level`=0, `dout_valid`=0, `upcounterfifo_AlmostFull`=0, `counter_en`=0 during reset.
- Sequence check (macro defined): corrupt one generator word by +2 → `seq_err` rises on the pop of that word and remains 1 until reset; with macro undefined, `seq_err` stays 0.
